// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the 2-input gate truth-table checker.
// Truth tables are indexed by the input vector {A,B}, so bit i is Y for vector i.
package gate_chk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        CHECK
    } state_e;

    localparam int unsigned NUM_VECTORS = 4;
    localparam int unsigned IDX_W       = 2;

    typedef logic [NUM_VECTORS-1:0] tt_t;
    typedef logic [IDX_W-1:0]       idx_t;

    localparam tt_t TT_AND  = 4'b1000;
    localparam tt_t TT_OR   = 4'b1110;
    localparam tt_t TT_NAND = 4'b0111;
    localparam tt_t TT_NOR  = 4'b0001;
    localparam tt_t TT_XOR  = 4'b0110;
    localparam tt_t TT_XNOR = 4'b1001;

    localparam idx_t LAST_IDX = idx_t'(NUM_VECTORS - 1);

endpackage

// File: rtl/gate_truth_table_checker_settle_timer.sv
// Settle-time counter: clears on request, counts while enabled and flags
// when the count has reached the programmed last value.
module settle_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] last_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        // NOTE: the default assignment first keeps every path assigned, so no latch is inferred.
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == last_i);

endmodule

// File: rtl/gate_truth_table_checker.sv
// Walks a 2-input gate through {A,B} = 00..11, samples Y after a settle time
// and compares the observed truth table with the one latched at start.
module gate_truth_table_checker
    import gate_chk_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] exp_tt,
    output logic       gate_a,
    output logic       gate_b,
    input  logic       gate_y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] obs_tt,
    output logic [3:0] err_mask
);

    // With no settle time each vector goes straight to its sample cycle.
    localparam state_e           FIRST_STATE = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
    localparam logic [CNT_W-1:0] SETTLE_LAST = (SETTLE_CYCLES == 0) ? '0
                                             : CNT_W'(SETTLE_CYCLES - 1);

    state_e state_q;
    idx_t   idx_q;
    tt_t    exp_q;
    tt_t    obs_q;
    tt_t    err_q;
    logic   gate_a_q;
    logic   gate_b_q;
    logic   busy_q;
    logic   done_q;
    logic   pass_q;

    logic   settle_clr;
    logic   settle_en;
    logic   settle_tc;

    // The counter only runs in SETTLE, so it always enters SETTLE from zero.
    assign settle_clr = (state_q != SETTLE) || abort;
    assign settle_en  = (state_q == SETTLE);

    settle_timer #(
        .CNT_W (CNT_W)
    ) u_settle_timer (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (settle_clr),
        .en_i   (settle_en),
        .last_i (SETTLE_LAST),
        .tc_o   (settle_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            exp_q    <= '0;
            obs_q    <= '0;
            err_q    <= '0;
            gate_a_q <= 1'b0;
            gate_b_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort && (state_q != IDLE)) begin
                // Abort beats everything, including the CHECK completion.
                state_q  <= IDLE;
                idx_q    <= '0;
                gate_a_q <= 1'b0;
                gate_b_q <= 1'b0;
                busy_q   <= 1'b0;
                pass_q   <= 1'b0;
                err_q    <= '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (start) begin
                            exp_q    <= exp_tt;
                            obs_q    <= '0;
                            err_q    <= '0;
                            pass_q   <= 1'b0;
                            idx_q    <= '0;
                            gate_a_q <= 1'b0;
                            gate_b_q <= 1'b0;
                            busy_q   <= 1'b1;
                            state_q  <= FIRST_STATE;
                        end
                    end
                    SETTLE: begin
                        if (settle_tc) begin
                            state_q <= SAMPLE;
                        end
                    end
                    SAMPLE: begin
                        obs_q[idx_q] <= gate_y;
                        if (idx_q == LAST_IDX) begin
                            state_q <= CHECK;
                        end else begin
                            idx_q                <= idx_q + 1'b1;
                            {gate_a_q, gate_b_q} <= idx_q + 1'b1;
                            state_q              <= FIRST_STATE;
                        end
                    end
                    CHECK: begin
                        err_q    <= obs_q ^ exp_q;
                        pass_q   <= (obs_q == exp_q);
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        gate_a_q <= 1'b0;
                        gate_b_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign gate_a   = gate_a_q;
    assign gate_b   = gate_b_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign obs_tt   = obs_q;
    assign err_mask = err_q;

endmodule

// File: doc/gate_truth_table_checker.md
Name: gate_truth_table_checker

Overview:
- Sequencer for a 2-input combinational logic gate (xnorg and siblings).
- On request, drives the gate's A/B inputs through all four combinations {A,B} = 00, 01, 10, 11, waits a programmable settle time, samples Y, and assembles the observed 4-entry truth table.
- Compares the observed table against an expected table and reports pass/fail plus a per-entry error mask.
- Used as an on-chip self-check wrapper around the logic-gate library cells, replacing hand-written stimulus.

Parameters:
- SETTLE_CYCLES, 2, clock cycles the inputs are held before sampling; range 0..255.
- CNT_W, 8, width of the settle counter; must hold SETTLE_CYCLES.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- start  input  1  level; sampled only in IDLE; begins a check run
- abort  input  1  level; cancels a run in progress
- exp_tt  input  4  expected truth table; bit index = {A,B}; latched on accepted start
- gate_a  output  1  drive to gate input A
- gate_b  output  1  drive to gate input B
- gate_y  input  1  gate output under test
- busy  output  1  high from the cycle after an accepted start until done or abort
- done  output  1  single-cycle pulse; result valid
- pass  output  1  1 when obs_tt == expected; held until next accepted start
- obs_tt  output  4  observed truth table; bit i = Y sampled for vector i
- err_mask  output  4  obs_tt XOR latched expected; held until next start

Behaviour:
- Reset (asynchronous, any state): state=IDLE; gate_a=0, gate_b=0, busy=0, done=0, pass=0, obs_tt=0, err_mask=0, vector index=0, settle count=0, latched expected=0.
- All outputs are registered. gate_y is sampled only in SAMPLE, on the clock edge ending that cycle.
- States: IDLE, SETTLE, SAMPLE, CHECK.
- IDLE:
  - start=1 at an edge → latch exp_tt; clear obs_tt, err_mask and pass; index=0; {gate_a,gate_b}=00; busy=1.
  - Next state is SETTLE, or SAMPLE if SETTLE_CYCLES=0.
- SETTLE:
  - Counts SETTLE_CYCLES cycles with the inputs stable, then moves to SAMPLE.
- SAMPLE (one cycle):
  - obs_tt[index] <= gate_y.
  - If index=3 → CHECK.
  - Otherwise index+1; {gate_a,gate_b} <= index+1; settle count cleared; → SETTLE, or SAMPLE again if SETTLE_CYCLES=0.
- CHECK (one cycle):
  - err_mask <= obs_tt XOR expected; pass <= (obs_tt == expected).
  - done=1 for this cycle only; busy <= 0; {gate_a,gate_b} <= 00; → IDLE.
- Latency: accepted start at edge k → done high in the cycle following edge k+4*(SETTLE_CYCLES+1)+1. With defaults, the done cycle begins at edge k+13.
- Boundary conditions:
  - start while busy: ignored; exp_tt changes mid-run have no effect.
  - start held high continuously: a new run begins in the IDLE cycle after done, so runs are back-to-back with one idle cycle between.
  - abort=1 in SETTLE/SAMPLE/CHECK: → IDLE next edge; busy=0; gate inputs=00; no done pulse; obs_tt keeps partial data; pass=0; err_mask=0.
  - abort=1 in IDLE: ignored.
  - abort and start in the same IDLE cycle: start wins.
  - abort has priority over CHECK completion.
  - Reset mid-run: immediate return to reset values; no done pulse.
  - Index increments 0→3 only; it never wraps within a run.

Decomposition:
- Package gate_chk_pkg:
  - state enum (IDLE, SETTLE, SAMPLE, CHECK)
  - NUM_VECTORS=4 and IDX_W=2
  - named expected-table constants: TT_AND=4'b1000, TT_OR=4'b1110, TT_NAND=4'b0111, TT_NOR=4'b0001, TT_XOR=4'b0110, TT_XNOR=4'b1001
- Sub-module settle_timer (CNT_W): load/clear, count-enable, terminal-count flag. It is instantiated once.
- The FSM and result registers live in the top module.

Test Plan:
- XNOR gate attached, exp_tt=TT_XNOR, start pulsed one cycle, defaults → gate inputs step 00,01,10,11 with 3 cycles each; done at start+13; obs_tt=1001, pass=1, err_mask=0000.
- XNOR gate attached, exp_tt=TT_XOR → done pulse; obs_tt=1001, pass=0, err_mask=1111.
- Y driven from a stuck-at-0 model, exp_tt=TT_XNOR → obs_tt=0000, err_mask=1001, pass=0. Then a second start with an XNOR model → pass=1 and err_mask cleared.
- SETTLE_CYCLES=0 → one cycle per vector; done at start+5; result matches the defaults case.
- abort asserted while index=2 → busy falls next edge, no done pulse, gate inputs=00, obs_tt[1:0]=01 for XNOR. A start issued while busy earlier in the run is ignored (exp_tt not re-latched).
- rst asserted asynchronously mid-SETTLE → all outputs 0 immediately. After release, a fresh start completes normally with pass=1.
